// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: turns MEM-stage control fields into a valid/ready data-bus
// request, stalls the pipeline while the access is in flight, and returns extended load data.
module mem_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_ena,
    input  logic        mem_wen,
    input  logic [3:0]  mem_mask,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_wdata,
    input  logic [1:0]  mem_sel_memdata,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [63:0] dmem_addr,
    output logic        dmem_wen,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_rsp_valid,
    input  logic [63:0] dmem_rdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [63:0] lsu_rdata,
    output logic        lsu_misalign,
    output logic        lsu_bus_err
);
    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        wen_q, wen_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [2:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [63:0] rdata_q, rdata_d;

    logic        acc;
    logic        misalign;
    logic [1:0]  size_in;
    logic [7:0]  bmask;
    logic [63:0] shifted;
    logic [63:0] ext_data;

    assign acc = in_valid & mem_ena;

    // size_in is log2 of the access width in bytes; anything not one-hot is a doubleword
    always_comb begin
        case (mem_mask)
            4'b0001: size_in = 2'd0;
            4'b0010: size_in = 2'd1;
            4'b0100: size_in = 2'd2;
            default: size_in = 2'd3;
        endcase
    end

    always_comb begin
        case (size_in)
            2'd0:    bmask = 8'h01;
            2'd1:    bmask = 8'h03;
            2'd2:    bmask = 8'h0F;
            default: bmask = 8'hFF;
        endcase
    end

    assign misalign = ((size_in == 2'd1) & mem_addr[0]) |
                      ((size_in == 2'd2) & (|mem_addr[1:0])) |
                      ((size_in == 2'd3) & (|mem_addr[2:0]));

    assign shifted = dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    ext_data = {{56{sext_q & shifted[7]}}, shifted[7:0]};
            2'd1:    ext_data = {{48{sext_q & shifted[15]}}, shifted[15:0]};
            2'd2:    ext_data = {{32{sext_q & shifted[31]}}, shifted[31:0]};
            default: ext_data = shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wen_d        = wen_q;
        wstrb_d      = wstrb_q;
        off_d        = off_q;
        size_d       = size_q;
        sext_d       = sext_q;
        rdata_d      = rdata_q;
        lsu_stall    = 1'b0;
        lsu_misalign = 1'b0;
        lsu_bus_err  = 1'b0;
        case (state_q)
            StIdle: begin
                if (acc && misalign) begin
                    lsu_misalign = 1'b1;
                end else if (acc) begin
                    lsu_stall = 1'b1;
                    addr_d    = {mem_addr[63:3], 3'b000};
                    wdata_d   = mem_wdata << {mem_addr[2:0], 3'b000};
                    wen_d     = mem_wen;
                    wstrb_d   = bmask << mem_addr[2:0];
                    off_d     = mem_addr[2:0];
                    size_d    = size_in;
                    sext_d    = (mem_sel_memdata == 2'b00);
                    state_d   = StReq;
                end
            end
            StReq: begin
                lsu_stall = 1'b1;
                if (dmem_req_ready) begin
                    cnt_d   = 8'd0;
                    state_d = StWait;
                end
            end
            StWait: begin
                lsu_stall = 1'b1;
                if (dmem_rsp_valid) begin
                    rdata_d = wen_q ? 64'd0 : ext_data;
                    state_d = StDone;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    lsu_bus_err = 1'b1;
                    rdata_d     = 64'd0;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            wen_q   <= 1'b0;
            wstrb_q <= 8'd0;
            off_q   <= 3'd0;
            size_q  <= 2'd0;
            sext_q  <= 1'b0;
            rdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            wstrb_q <= wstrb_d;
            off_q   <= off_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            rdata_q <= rdata_d;
        end
    end

    assign dmem_req_valid = (state_q == StReq);
    assign lsu_done       = (state_q == StDone);
    assign dmem_addr      = addr_q;
    assign dmem_wen       = wen_q;
    assign dmem_wdata     = wdata_q;
    assign dmem_wstrb     = wstrb_q;
    assign lsu_rdata      = rdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a cycle-level expectation model driven alongside the stimulus,
// checked every cycle, plus literal checks of hand-computed results.
module tb_mem_lsu;
    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mem_ena, mem_wen;
    logic [3:0]  mem_mask;
    logic [63:0] mem_addr, mem_wdata;
    logic [1:0]  mem_sel_memdata;
    logic        dmem_req_valid, dmem_req_ready, dmem_wen, dmem_rsp_valid;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_wstrb;
    logic        lsu_stall, lsu_done, lsu_misalign, lsu_bus_err;
    logic [63:0] lsu_rdata;

    mem_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_ena(mem_ena), .mem_wen(mem_wen),
        .mem_mask(mem_mask), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_sel_memdata(mem_sel_memdata), .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rdata(dmem_rdata), .lsu_stall(lsu_stall), .lsu_done(lsu_done),
        .lsu_rdata(lsu_rdata), .lsu_misalign(lsu_misalign), .lsu_bus_err(lsu_bus_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // expected outputs for the current cycle
    logic        e_stall, e_req, e_done, e_mis, e_berr, e_fchk, e_dwen;
    logic [63:0] e_rdata, e_addr, e_wdata;
    logic [7:0]  e_strb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 64'(lsu_stall), 64'(e_stall));
            chk("req_valid", 64'(dmem_req_valid), 64'(e_req));
            chk("done", 64'(lsu_done), 64'(e_done));
            chk("misalign", 64'(lsu_misalign), 64'(e_mis));
            chk("bus_err", 64'(lsu_bus_err), 64'(e_berr));
            chk("rdata", lsu_rdata, e_rdata);
            if (e_fchk) begin
                chk("dmem_addr", dmem_addr, e_addr);
                chk("dmem_wen", 64'(dmem_wen), 64'(e_dwen));
                chk("dmem_wdata", dmem_wdata, e_wdata);
                chk("dmem_wstrb", 64'(dmem_wstrb), 64'(e_strb));
            end
        end
    end

    function automatic int nbytes(input logic [3:0] m);
        case (m)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [63:0] lane_mask(input int n);
        return (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [63:0] a,
                                           input logic [3:0] m, input logic [1:0] sel);
        int n = nbytes(m);
        logic [63:0] v = (rd >> (8 * int'(a[2:0]))) & lane_mask(n);
        if (sel == 2'b00 && n < 8 && v[8 * n - 1]) v = v | ~lane_mask(n);
        return v;
    endfunction

    function automatic logic [7:0] m_strb(input logic [63:0] a, input logic [3:0] m);
        logic [15:0] s = ((16'd1 << nbytes(m)) - 16'd1) << a[2:0];
        return s[7:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_quiet();
        e_stall = 0; e_req = 0; e_done = 0; e_mis = 0; e_berr = 0; e_fchk = 0;
    endtask

    task automatic idle_cyc(input logic iv, input logic en);
        in_valid = iv; mem_ena = en; mem_wen = 0; mem_mask = 4'b1000;
        dmem_req_ready = 0; dmem_rsp_valid = 0;
        exp_quiet();
        cyc();
    endtask

    // wdly < 0 means no response ever arrives
    task automatic run_acc(input logic [63:0] a, input logic [3:0] m, input logic w,
                           input logic [63:0] wd, input logic [1:0] sel, input logic [63:0] rd,
                           input int rdly, input int wdly, output logic [63:0] g_rdata,
                           output logic [63:0] g_addr, output logic [63:0] g_wdata,
                           output logic [7:0] g_strb);
        logic to;
        in_valid = 1; mem_ena = 1; mem_wen = w; mem_mask = m; mem_addr = a;
        mem_wdata = wd; mem_sel_memdata = sel; dmem_rdata = rd;
        dmem_req_ready = 0; dmem_rsp_valid = 0;
        exp_quiet();
        if ((int'(a[2:0]) % nbytes(m)) != 0) begin
            e_mis = 1;
            cyc();
        end else begin
            e_stall = 1;
            cyc();
            e_req = 1; e_fchk = 1; e_dwen = w; e_addr = a & ~64'h7;
            e_wdata = wd << (8 * int'(a[2:0])); e_strb = m_strb(a, m);
            for (int i = 0; i <= rdly; i++) begin
                dmem_req_ready = (i == rdly);
                cyc();
            end
            g_addr = dmem_addr; g_wdata = dmem_wdata; g_strb = dmem_wstrb;
            dmem_req_ready = 0; e_req = 0; e_fchk = 0;
            to = 0;
            for (int wc = 0; wc <= TO; wc++) begin
                if (wc == wdly) begin
                    dmem_rsp_valid = 1;
                    cyc();
                    break;
                end
                if (wc == TO) begin
                    e_berr = 1; to = 1;
                end
                cyc();
            end
            dmem_rsp_valid = 0; e_berr = 0;
            e_stall = 0; e_done = 1;
            e_rdata = (to || w) ? 64'd0 : m_load(rd, a, m, sel);
            cyc();
            g_rdata = lsu_rdata;
        end
        in_valid = 0; mem_ena = 0;
        exp_quiet();
    endtask

    logic [63:0] gr, ga, gw;
    logic [7:0]  gs;

    initial begin
        rst = 1; in_valid = 0; mem_ena = 0; mem_wen = 0; mem_mask = 0; mem_addr = 0;
        mem_wdata = 0; mem_sel_memdata = 0; dmem_req_ready = 0; dmem_rsp_valid = 0;
        dmem_rdata = 0;
        exp_quiet(); e_rdata = 0;
        e_fchk = 1; e_addr = 0; e_wdata = 0; e_strb = 0; e_dwen = 0;
        cyc(); cyc();
        chk_en = 1;
        cyc();
        rst = 0;
        idle_cyc(0, 0);

        // LB sign-extended from lane 3
        run_acc(64'h8000_0003, 4'b0001, 0, 0, 2'b00, 64'h0000_0000_80FF_0000, 0, 0, gr, ga, gw, gs);
        chk("lit_lb", gr, 64'hFFFF_FFFF_FFFF_FF80);
        idle_cyc(0, 0);
        // LHU
        run_acc(64'h8000_0006, 4'b0010, 0, 0, 2'b01, 64'hBEEF_0000_0000_0000, 0, 0, gr, ga, gw, gs);
        chk("lit_lhu", gr, 64'h0000_0000_0000_BEEF);
        // SW upper word, back-to-back with the previous access
        run_acc(64'h8000_0004, 4'b0100, 1, 64'h1234_5678, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF,
                0, 0, gr, ga, gw, gs);
        chk("lit_sw_addr", ga, 64'h8000_0000);
        chk("lit_sw_strb", 64'(gs), 64'hF0);
        chk("lit_sw_wdata", gw, 64'h1234_5678_0000_0000);
        chk("lit_sw_rdata", gr, 64'd0);
        idle_cyc(0, 0);

        // misaligned accesses and non-memory instructions
        run_acc(64'h8000_0004, 4'b1000, 1, 64'h55, 2'b00, 0, 0, 0, gr, ga, gw, gs);
        idle_cyc(0, 0);
        run_acc(64'h8000_0001, 4'b0010, 0, 0, 2'b00, 0, 0, 0, gr, ga, gw, gs);
        run_acc(64'h8000_0002, 4'b0100, 0, 0, 2'b00, 0, 0, 0, gr, ga, gw, gs);
        run_acc(64'h8000_0004, 4'b0011, 0, 0, 2'b00, 0, 0, 0, gr, ga, gw, gs);
        idle_cyc(1, 0);
        idle_cyc(0, 1);

        // stalled request and delayed response
        run_acc(64'h8000_0014, 4'b0100, 0, 0, 2'b00, 64'h8765_4321_0000_0000, 5, 3,
                gr, ga, gw, gs);
        chk("lit_lw_slow", gr, 64'hFFFF_FFFF_8765_4321);
        idle_cyc(0, 0);
        // no response: bus error after the timeout, rdata cleared
        run_acc(64'h8000_0008, 4'b1000, 0, 0, 2'b00, 64'h1111_2222_3333_4444, 0, -1,
                gr, ga, gw, gs);
        chk("lit_timeout", gr, 64'd0);
        idle_cyc(0, 0);

        run_acc(64'h8000_0005, 4'b0001, 1, 64'hAB, 2'b00, 0, 1, 1, gr, ga, gw, gs);
        chk("lit_sb_strb", 64'(gs), 64'h20);
        chk("lit_sb_wdata", gw, 64'h0000_AB00_0000_0000);
        run_acc(64'h8000_0002, 4'b0010, 1, 64'h1234, 2'b00, 0, 0, 2, gr, ga, gw, gs);
        chk("lit_sh_strb", 64'(gs), 64'h0C);
        run_acc(64'h8000_0008, 4'b0011, 0, 0, 2'b00, 64'h0123_4567_89AB_CDEF, 0, 0,
                gr, ga, gw, gs);
        chk("lit_ld_nonhot", gr, 64'h0123_4567_89AB_CDEF);
        run_acc(64'h8000_0003, 4'b0001, 0, 0, 2'b10, 64'h0000_0000_80FF_0000, 0, 0,
                gr, ga, gw, gs);
        chk("lit_lbu", gr, 64'h80);
        run_acc(64'h8000_0002, 4'b0010, 0, 0, 2'b00, 64'h0000_0000_8001_0000, 0, 0,
                gr, ga, gw, gs);
        chk("lit_lh", gr, 64'hFFFF_FFFF_FFFF_8001);

        // reset while waiting for the response, then a late response
        in_valid = 1; mem_ena = 1; mem_wen = 0; mem_mask = 4'b1000; mem_addr = 64'h8000_0010;
        mem_sel_memdata = 0; dmem_rdata = 64'hDEAD_BEEF_0000_0001;
        exp_quiet(); e_stall = 1;
        cyc();
        dmem_req_ready = 1; e_req = 1;
        cyc();
        dmem_req_ready = 0; e_req = 0;
        cyc();
        rst = 1;
        cyc();
        rst = 0; in_valid = 0; mem_ena = 0; dmem_rsp_valid = 1;
        exp_quiet(); e_rdata = 0;
        e_fchk = 1; e_addr = 0; e_wdata = 0; e_strb = 0; e_dwen = 0;
        cyc();
        dmem_rsp_valid = 0;
        cyc();
        cyc();
        chk_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
